// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating counters; zero-latency lookup, EX-stage updates.
// Optional BP_STATS_EN adds saturating resolve/jump/load event counters.
module branch_target_predictor #(
  parameter int         IDX_BITS = 5,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_if_pc,
  output logic        o_prediction,
  output logic [31:0] o_btb_target,
  output logic        o_btb_hit,
  input  logic        i_res_valid,
  input  logic [31:0] i_res_pc,
  input  logic        i_res_is_jump,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  input  logic        i_load_btb
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_jumps,
  output logic [31:0] o_stat_loads
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic               r_valid  [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic               r_is_jump[ENTRIES];
  logic               r_armed;

  logic [IDX_BITS-1:0] w_lidx, w_ridx;
  logic [TAG_W-1:0]    w_ltag, w_rtag;
  logic                w_rhit, w_upd;
  logic                w_unused;

  assign w_lidx   = i_if_pc[IDX_BITS+1:2];
  assign w_ltag   = i_if_pc[31:IDX_BITS+2];
  assign w_ridx   = i_res_pc[IDX_BITS+1:2];
  assign w_rtag   = i_res_pc[31:IDX_BITS+2];
  assign w_unused = &{1'b0, i_if_pc[1:0], i_res_pc[1:0]};

  assign o_btb_hit    = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign o_prediction = o_btb_hit && (r_is_jump[w_lidx] || r_ctr[w_lidx][1]);
  assign o_btb_target = o_prediction ? r_target[w_lidx] : i_if_pc + 32'd4;

  assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  // r_armed suppresses writes on the first edge after reset release.
  assign w_upd  = r_armed && i_res_valid;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
    end else begin
      r_armed <= 1'b1;
      if (w_upd) begin
        if (i_load_btb) begin
          r_valid[w_ridx] <= 1'b1;
          if (!w_rhit)
            r_ctr[w_ridx] <= i_res_taken ? 2'b10 : CTR_INIT;
          else if (!i_res_is_jump)
            r_ctr[w_ridx] <= sat_update(r_ctr[w_ridx], i_res_taken);
        end else if (w_rhit && !i_res_is_jump) begin
          r_ctr[w_ridx] <= sat_update(r_ctr[w_ridx], i_res_taken);
        end
      end
    end
  end

  // Payload fields are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_upd && i_load_btb && !rst) begin
      r_tag[w_ridx]     <= w_rtag;
      r_target[w_ridx]  <= i_res_target;
      r_is_jump[w_ridx] <= i_res_is_jump;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stat_branches <= '0;
      o_stat_jumps    <= '0;
      o_stat_loads    <= '0;
    end else if (w_upd) begin
      if (!i_res_is_jump && o_stat_branches != 32'hFFFF_FFFF)
        o_stat_branches <= o_stat_branches + 32'd1;
      if (i_res_is_jump && o_stat_jumps != 32'hFFFF_FFFF)
        o_stat_jumps <= o_stat_jumps + 32'd1;
      if (i_load_btb && o_stat_loads != 32'hFFFF_FFFF)
        o_stat_loads <= o_stat_loads + 32'd1;
    end
  end
`endif

endmodule
